// File: rtl/ctl_pkg.sv
// ctl_pkg: shared state enum, opcode/ALU/PC-control codes and decoded-field struct for ctl_fsm
package ctl_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    BRANCH = 3'd4,
    HALT   = 3'd5
  } state_t;
  typedef enum logic [1:0] {CLS_ALU, CLS_BR, CLS_JMP} cls_t;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_NOT = 2'b10;
  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  typedef struct packed {
    cls_t       cls;
    logic [1:0] alu_op;
    logic [2:0] dr;
    logic [2:0] sr1;
    logic [2:0] sr2;
    logic       imm_sel;
    logic [4:0] imm5;
  } fields_t;
endpackage

// File: rtl/ctl_fsm_if.sv
// ctl_fsm_if: sequencer bus (fetch handshake, branch-FSM strobes, datapath fields, PC control); master = ctl_fsm, slave = environment
interface ctl_fsm_if;
  logic        run_in;
  logic [15:0] instr_in;
  logic        instr_valid_in;
  logic        pc_ctl_0_in;
  logic        fetch_req_out;
  logic        we_reg_out;
  logic        br_out;
  logic        n_dec_out;
  logic        z_dec_out;
  logic        p_dec_out;
  logic [1:0]  alu_op_out;
  logic [2:0]  dr_out;
  logic [2:0]  sr1_out;
  logic [2:0]  sr2_out;
  logic        imm_sel_out;
  logic [4:0]  imm5_out;
  logic        pc_ld_out;
  logic [1:0]  pc_ctl_out;
  logic        illegal_out;
  logic [2:0]  state_out;
  logic [15:0] retired_cnt_out;
  modport master (
    input  run_in, instr_in, instr_valid_in, pc_ctl_0_in,
    output fetch_req_out, we_reg_out, br_out, n_dec_out, z_dec_out, p_dec_out,
           alu_op_out, dr_out, sr1_out, sr2_out, imm_sel_out, imm5_out,
           pc_ld_out, pc_ctl_out, illegal_out, state_out, retired_cnt_out
  );
  modport slave (
    output run_in, instr_in, instr_valid_in, pc_ctl_0_in,
    input  fetch_req_out, we_reg_out, br_out, n_dec_out, z_dec_out, p_dec_out,
           alu_op_out, dr_out, sr1_out, sr2_out, imm_sel_out, imm5_out,
           pc_ld_out, pc_ctl_out, illegal_out, state_out, retired_cnt_out
  );
endinterface

// File: rtl/ctl_field_dec.sv
// ctl_field_dec: combinational IR decode; in ir[15:0], out f (fields/opcode class/ALU op), illegal (opcode outside ADD/AND/NOT/BR/JMP)
module ctl_field_dec
  import ctl_pkg::*;
(
  input  logic [15:0] ir,
  output fields_t     f,
  output logic        illegal
);
  logic [3:0] op;
  assign op = ir[15:12];
  always_comb begin
    f.cls     = op == OP_BR ? CLS_BR : op == OP_JMP ? CLS_JMP : CLS_ALU;
    f.alu_op  = op == OP_AND ? ALU_AND : op == OP_NOT ? ALU_NOT : ALU_ADD;
    f.dr      = ir[11:9];
    f.sr1     = ir[8:6];
    f.sr2     = ir[2:0];
    f.imm_sel = ir[5];
    f.imm5    = ir[4:0];
    illegal   = !(op inside {OP_ADD, OP_AND, OP_NOT, OP_BR, OP_JMP});
  end
endmodule

// File: rtl/ctl_fsm.sv
// ctl_fsm: instruction sequencer; ports clka, reset_in (sync active-low), bus (ctl_fsm_if.master); macro CTL_RETIRE_CNT_EN enables the retired-instruction counter
module ctl_fsm
  import ctl_pkg::*;
(
  input logic       clka,
  input logic       reset_in,
  ctl_fsm_if.master bus
);
  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  fields_t     f_q, f_d, f_dec;
  logic        illegal, exec, br, pc_ld;
  ctl_field_dec u_dec (.ir(ir_q), .f(f_dec), .illegal(illegal));
  always_ff @(posedge clka) begin
    if (!reset_in) begin
      state_q <= IDLE;
      ir_q    <= '0;
      f_q     <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      f_q     <= f_d;
    end
  end
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    f_d     = f_q;
    case (state_q)
      IDLE:   state_d = bus.run_in ? FETCH : IDLE;
      FETCH: begin
        ir_d    = bus.instr_valid_in ? bus.instr_in : ir_q;
        state_d = bus.instr_valid_in ? DECODE : FETCH;
      end
      DECODE: begin
        f_d     = f_dec;
        state_d = illegal ? HALT : EXEC;
      end
      EXEC:   state_d = f_q.cls == CLS_BR ? BRANCH : bus.run_in ? FETCH : IDLE;
      BRANCH: state_d = bus.run_in ? FETCH : IDLE;
      HALT:   state_d = HALT;
      default: state_d = IDLE;
    endcase
  end
  assign exec  = state_q == EXEC;
  assign br    = exec && f_q.cls == CLS_BR;
  assign pc_ld = (exec && f_q.cls != CLS_BR) || state_q == BRANCH;
  assign bus.fetch_req_out = state_q == FETCH;
  assign bus.we_reg_out    = exec && f_q.cls == CLS_ALU;
  assign bus.br_out        = br;
  assign {bus.n_dec_out, bus.z_dec_out, bus.p_dec_out} = br ? f_q.dr : 3'b000;
  assign bus.alu_op_out    = f_q.alu_op;
  assign bus.dr_out        = f_q.dr;
  assign bus.sr1_out       = f_q.sr1;
  assign bus.sr2_out       = f_q.sr2;
  assign bus.imm_sel_out   = f_q.imm_sel;
  assign bus.imm5_out      = f_q.imm5;
  assign bus.pc_ld_out     = pc_ld;
  assign bus.pc_ctl_out    = state_q == BRANCH ? (bus.pc_ctl_0_in ? PC_BR : PC_INC) :
                             (exec && f_q.cls == CLS_JMP) ? PC_JMP : PC_INC;
  assign bus.illegal_out   = state_q == HALT;
  assign bus.state_out     = state_q;
`ifdef CTL_RETIRE_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = cnt_q + {15'd0, pc_ld};
  always_ff @(posedge clka) begin
    if (!reset_in) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign bus.retired_cnt_out = cnt_q;
`else
  assign bus.retired_cnt_out = '0;
`endif
endmodule

// File: tb/tb_ctl_fsm.sv
// tb_ctl_fsm: scoreboard bench for ctl_fsm; expected PC actions queued at fetch, checked on each pc_ld pulse
module tb_ctl_fsm;
  logic clka = 1'b0;
  logic reset_in = 1'b0;
  ctl_fsm_if bus();
  ctl_fsm dut (.clka(clka), .reset_in(reset_in), .bus(bus));
  always #5 clka = ~clka;
  typedef struct {
    logic [1:0] pc_ctl;
    logic       we;
    logic       is_br;
    logic [2:0] nzp;
    logic [2:0] dr;
    logic [2:0] sr1;
    logic [2:0] sr2;
    logic       imm_sel;
    logic [4:0] imm5;
    logic [1:0] alu;
    int         ld_cyc;
  } exp_t;
  exp_t sb[$];
  exp_t me;
  int n_chk = 0, n_fail = 0, cyc = 0, issue_cyc = 0, exp_cnt = 0, t0 = 0;
  logic mon_en = 1'b0, br_prev = 1'b0, ld_prev = 1'b0;
  logic [2:0] nzp_prev = 3'b000;
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask
  function automatic logic [63:0] outs();
    return 64'({bus.fetch_req_out, bus.we_reg_out, bus.br_out, bus.n_dec_out, bus.z_dec_out,
                bus.p_dec_out, bus.alu_op_out, bus.dr_out, bus.sr1_out, bus.sr2_out,
                bus.imm_sel_out, bus.imm5_out, bus.pc_ld_out, bus.pc_ctl_out,
                bus.illegal_out, bus.state_out, bus.retired_cnt_out});
  endfunction
  function automatic exp_t model(input logic [15:0] i, input logic taken);
    exp_t e;
    logic [3:0] op;
    op        = i[15:12];
    e.is_br   = op == 4'h0;
    e.we      = op == 4'h1 || op == 4'h5 || op == 4'h9;
    e.pc_ctl  = op == 4'hC ? 2'b10 : (e.is_br && taken) ? 2'b01 : 2'b00;
    e.alu     = op == 4'h5 ? 2'b01 : op == 4'h9 ? 2'b10 : 2'b00;
    e.nzp     = i[11:9];
    e.dr      = i[11:9];
    e.sr1     = i[8:6];
    e.sr2     = i[2:0];
    e.imm_sel = i[5];
    e.imm5    = i[4:0];
    e.ld_cyc  = 0;
    return e;
  endfunction
  always @(posedge clka) cyc++;
  always @(negedge clka) begin
    if (mon_en) begin
      check("we_without_ld", 64'(bus.we_reg_out & ~bus.pc_ld_out), 64'd0);
      check("br_with_ld", 64'(bus.br_out & bus.pc_ld_out), 64'd0);
      check("ld_twice", 64'(ld_prev & bus.pc_ld_out), 64'd0);
      check("nzp_without_br", 64'({bus.n_dec_out, bus.z_dec_out, bus.p_dec_out} & {3{~bus.br_out}}), 64'd0);
      if (bus.pc_ld_out) begin
        if (sb.size() == 0) check("unexpected_pc_ld", 64'(bus.pc_ld_out), 64'd0);
        else begin
          me = sb.pop_front();
          check("pc_ctl", 64'(bus.pc_ctl_out), 64'(me.pc_ctl));
          check("we_reg", 64'(bus.we_reg_out), 64'(me.we));
          check("alu_op", 64'(bus.alu_op_out), 64'(me.alu));
          check("dr", 64'(bus.dr_out), 64'(me.dr));
          check("sr1", 64'(bus.sr1_out), 64'(me.sr1));
          check("sr2", 64'(bus.sr2_out), 64'(me.sr2));
          check("imm_sel", 64'(bus.imm_sel_out), 64'(me.imm_sel));
          check("imm5", 64'(bus.imm5_out), 64'(me.imm5));
          check("pc_ld_latency", 64'(cyc), 64'(me.ld_cyc));
          check("br_before_ld", 64'(br_prev), 64'(me.is_br));
          if (me.is_br) check("nzp", 64'(nzp_prev), 64'(me.nzp));
        end
      end
    end
    ld_prev  = bus.pc_ld_out;
    br_prev  = bus.br_out;
    nzp_prev = {bus.n_dec_out, bus.z_dec_out, bus.p_dec_out};
  end
  task automatic step();
    @(posedge clka);
    #1;
  endtask
  task automatic issue(input logic [15:0] instr, input int stall, input logic taken);
    exp_t e;
    int n = 0;
    while (!bus.fetch_req_out && n < 50) begin
      step();
      n++;
    end
    check("fetch_req_wait", 64'(bus.fetch_req_out), 64'd1);
    for (int s = 0; s < stall; s++) begin
      bus.instr_valid_in = 1'b0;
      check("stall_fetch_req", 64'(bus.fetch_req_out), 64'd1);
      check("stall_state", 64'(bus.state_out), 64'd1);
      step();
    end
    bus.instr_in       = instr;
    bus.instr_valid_in = 1'b1;
    bus.pc_ctl_0_in    = taken;
    issue_cyc          = cyc;
    if (instr[15:12] inside {4'h1, 4'h5, 4'h9, 4'h0, 4'hC}) begin
      e = model(instr, taken);
      e.ld_cyc = cyc + (e.is_br ? 3 : 2);
      sb.push_back(e);
`ifdef CTL_RETIRE_CNT_EN
      exp_cnt++;
`endif
    end
    step();
    bus.instr_valid_in = 1'b0;
    bus.instr_in       = 16'($urandom);
  endtask
  task automatic wait_state(input logic [2:0] s, input string tag);
    int n = 0;
    while (bus.state_out !== s && n < 50) begin
      step();
      n++;
    end
    check(tag, 64'(bus.state_out), 64'(s));
  endtask
  task automatic do_reset(input int cycles);
    check("sb_empty_at_reset", 64'(sb.size()), 64'd0);
    sb.delete();
    exp_cnt = 0;
    reset_in = 1'b0;
    bus.instr_valid_in = 1'b0;
    repeat (cycles) @(posedge clka);
    #1;
    check("reset_outs", outs(), 64'd0);
    reset_in = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: no finish by time %0t", $time);
    $fatal(1, "watchdog expired");
  end
  initial begin
    bus.run_in = 1'b0;
    bus.instr_valid_in = 1'b0;
    bus.instr_in = 16'h0000;
    bus.pc_ctl_0_in = 1'b0;
    do_reset(2);
    mon_en = 1'b1;
    bus.instr_in = 16'h1283;
    bus.instr_valid_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("idle_outs", outs(), 64'd0);
      step();
    end
    bus.instr_valid_in = 1'b0;
    bus.run_in = 1'b1;
    issue(16'h1283, 0, 1'b1);
    issue(16'h0800, 0, 1'b1);
    issue(16'h0800, 0, 1'b0);
    issue(16'h0000, 0, 1'b1);
    issue(16'h0000, 0, 1'b0);
    issue(16'hC080, 5, 1'b1);
    issue(16'h5A65, 0, 1'b1);
    t0 = issue_cyc;
    issue(16'h93FF, 0, 1'b1);
    check("back_to_back_cycles", 64'(issue_cyc - t0), 64'd3);
    issue(16'h0E00, 0, 1'b1);
    bus.run_in = 1'b0;
    wait_state(3'd0, "run_drop_idle");
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_after_drop", 64'({bus.fetch_req_out, bus.state_out}), 64'd0);
    end
    check("retired_cnt_total", 64'(bus.retired_cnt_out), 64'(exp_cnt));
    do_reset(2);
    bus.run_in = 1'b1;
    issue(16'h1283, 0, 1'b0);
    issue(16'h0800, 0, 1'b1);
    issue(16'hC080, 0, 1'b0);
    bus.run_in = 1'b0;
    wait_state(3'd0, "cnt_idle");
    check("retired_cnt_three", 64'(bus.retired_cnt_out), 64'(exp_cnt));
    do_reset(2);
    bus.run_in = 1'b1;
    issue(16'hD000, 0, 1'b0);
    step();
    for (int i = 0; i < 10; i++) begin
      bus.instr_valid_in = 1'b1;
      bus.instr_in = 16'h1283;
      check("halt_state", 64'(bus.state_out), 64'd5);
      check("halt_illegal", 64'(bus.illegal_out), 64'd1);
      check("halt_no_fetch", 64'(bus.fetch_req_out), 64'd0);
      step();
    end
    do_reset(2);
    bus.run_in = 1'b1;
    issue(16'h0800, 0, 1'b1);
    wait_state(3'd4, "reach_branch");
    reset_in = 1'b0;
    step();
    check("reset_in_branch", outs(), 64'd0);
    reset_in = 1'b1;
    bus.run_in = 1'b0;
    step();
    check("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ctl_fsm.md
# ctl_fsm

Instruction sequencer that drives the condition-code/branch FSM from the decoder side. It fetches a 16-bit instruction over a valid handshake and decodes the ADD/AND/NOT/BR/JMP subset. It generates `we_reg`, `br` and `n/z/p_dec` for the branch FSM and consumes that FSM's `pc_ctl_0` result to select the next-PC action. It sits between instruction memory and the datapath/PC unit.

## Interface
- No parameters; instruction width fixed at 16.
- `clka` in 1: single clock, rising edge.
- `reset_in` in 1: synchronous, active-low reset.
- `run_in` in 1: level; permits leaving IDLE and starting a new fetch.
- `instr_in` in 16: instruction word.
- `instr_valid_in` in 1: `instr_in` valid this cycle.
- `pc_ctl_0_in` in 1: branch-taken result from the branch FSM.
- `fetch_req_out` out 1: requesting an instruction.
- `we_reg_out` out 1: register/CC write strobe.
- `br_out` out 1: branch-evaluate strobe.
- `n_dec_out`, `z_dec_out`, `p_dec_out` out 1 each: BR condition bits.
- `alu_op_out` out 2: 00 ADD, 01 AND, 10 NOT.
- `dr_out`, `sr1_out`, `sr2_out` out 3 each: register addresses.
- `imm_sel_out` out 1: use imm5.
- `imm5_out` out 5: immediate field.
- `pc_ld_out` out 1: one-cycle PC update strobe.
- `pc_ctl_out` out 2: 00 PC+1, 01 branch target, 10 JMP base (`sr1_out`).
- `illegal_out` out 1: sticky illegal-opcode flag.
- `state_out` out 3: current state encoding.
- `retired_cnt_out` out 16: retired instruction count (see Configuration).

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, BRANCH=4, HALT=5. Codes 6–7 are unreachable; if entered, the next state is IDLE.
- IDLE → FETCH when `run_in`=1.
- FETCH: `fetch_req_out`=1. On `instr_valid_in`=1, latch IR and go to DECODE; otherwise hold in FETCH.
- DECODE: register all field outputs from IR.
  - `dr` = IR[11:9], `sr1` = IR[8:6], `sr2` = IR[2:0], `imm_sel` = IR[5], `imm5` = IR[4:0].
  - Opcode IR[15:12]: 0001 ADD, 0101 AND, 1001 NOT, 0000 BR, 1100 JMP.
  - Any other opcode goes to HALT.
  - Otherwise go to EXEC.
- EXEC behaviour by opcode:
  - ADD/AND/NOT: `we_reg_out`=1 for this cycle only, `pc_ld_out`=1, `pc_ctl_out`=00.
  - JMP: `pc_ld_out`=1, `pc_ctl_out`=10; `we_reg_out` stays 0.
  - BR: `br_out`=1 and `n/z/p_dec_out` = IR[11:9] for this cycle only; then go to BRANCH.
- BRANCH: sample `pc_ctl_0_in`. Drive `pc_ld_out`=1 with `pc_ctl_out`=01 if it is 1, else 00.
- End of instruction (EXEC for non-BR, BRANCH for BR): next state is FETCH if `run_in`=1, else IDLE.
- HALT: `illegal_out`=1. Stay in HALT until reset; `run_in` is ignored.
- Outside their asserting cycle, all strobes (`we_reg`, `br`, `n/z/p_dec`, `pc_ld`, `fetch_req`) are 0.

## Timing
- Reset (`reset_in`=0 at a rising edge) clears everything, including mid-instruction:
  - state → IDLE, IR=0.
  - All outputs 0, including `illegal_out` and `retired_cnt_out`.
- Latency from the `instr_valid_in` edge:
  - ALU op or JMP: `pc_ld_out` two cycles later (DECODE, then EXEC).
  - BR: `pc_ld_out` three cycles later (EXEC, then BRANCH).
- `pc_ctl_0_in` must be valid in the cycle after `br_out`. It is ignored in all other states.
- `instr_valid_in` outside FETCH is ignored.
- With `run_in` held high, back-to-back ALU ops take 3 cycles each when memory answers immediately.
- BR with nzp=000: `br_out` still pulses, and `pc_ctl_out`=00 unless `pc_ctl_0_in`=1. The PC action follows `pc_ctl_0_in` unconditionally.
- `run_in` dropping mid-instruction: the current instruction completes, then the block goes to IDLE.

## Configuration
- `CTL_RETIRE_CNT_EN` defined:
  - 16-bit counter, incremented on each `pc_ld_out` pulse.
  - Wraps from 0xFFFF to 0x0000.
  - Cleared by reset.
- `CTL_RETIRE_CNT_EN` undefined: `retired_cnt_out` is tied to 0 and the counter register is absent.

## Structure
- Shared package `ctl_pkg`:
  - state enum (IDLE..HALT);
  - opcode constants (OP_ADD, OP_AND, OP_NOT, OP_BR, OP_JMP);
  - ALU op codes;
  - `pc_ctl` codes (PC_INC, PC_BR, PC_JMP).
- One sub-module `ctl_field_dec`: combinational IR → fields/opcode-class/illegal decode, registered by the parent in DECODE.

## Test plan
- Reset and idle:
  - `reset_in`=0 for 2 cycles, then 1 with `run_in`=0 → `state_out`=0 and all outputs 0 indefinitely.
  - `instr_valid_in`=1 in this condition is ignored.
- ADD:
  - `run_in`=1, `instr_in`=0x1283 valid on the first FETCH cycle.
  - DECODE gives `dr`=1, `sr1`=2, `sr2`=3, `imm_sel`=0.
  - Next cycle: `we_reg_out`=1, `pc_ld_out`=1, `pc_ctl_out`=00, each for exactly one cycle.
- BR taken vs not taken, `instr_in`=0x0800 (n=1):
  - EXEC: `br_out`=1, `n_dec_out`=1, `z_dec_out`=0, `p_dec_out`=0.
  - `pc_ctl_0_in`=1 in BRANCH → `pc_ctl_out`=01.
  - Repeat with 0 → 00.
- Fetch stall and JMP:
  - Hold `instr_valid_in`=0 for 5 cycles → `fetch_req_out`=1 and `state_out`=1 throughout.
  - Then 0xC080 → `pc_ctl_out`=10, `sr1_out`=2.
- Illegal opcode and reset recovery:
  - `instr_in`=0xD000 → `state_out`=5, `illegal_out`=1, held for 10 cycles with `run_in`=1.
  - Reset asserted in BRANCH → IDLE with all outputs 0 on the next edge.
- Counter (`CTL_RETIRE_CNT_EN` defined): 3 instructions → `retired_cnt_out`=3; reset → 0.
